// File: rtl/sd_cmd_phy.sv
// SD command-line PHY: serializes a 48-bit command frame with CRC7, then
// receives and checks the 48-bit card response and hands it back upstream.
module sd_cmd_phy #(
    parameter int RESP_TIMEOUT = 64
) (
    input  logic        iClock_host,
    input  logic        iReset,
    input  logic        iBit_tick,
    input  logic        iStrobe_in,
    input  logic [37:0] iCmd_in,
    input  logic        iAck_in,
    input  logic        iCmd_line,
    output logic        oCmd_line,
    output logic        oCmd_oe,
    output logic        oAck_out,
    output logic        oStrobe_out,
    output logic [37:0] oCmd_out,
    output logic        oCrc_error,
    output logic        oTimeout,
    output logic        oIdle
);

    localparam logic [2:0] ST_RESET   = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_SEND    = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_RECV    = 3'd4;
    localparam logic [2:0] ST_DELIVER = 3'd5;

    localparam int WAIT_W = $clog2(RESP_TIMEOUT + 1);

    logic [2:0]        state;
    logic [47:0]       shift;
    logic [5:0]        bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [6:0]        rx_crc;
    logic [39:0]       tx_content;
    logic [6:0]        tx_crc;

    // One MSB-first step of CRC7 (x^7 + x^3 + 1).
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_word(input logic [39:0] word);
        logic [6:0] crc;
        crc = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            crc = crc7_step(crc, word[i]);
        end
        return crc;
    endfunction

    assign tx_content = {2'b01, iCmd_in};
    assign tx_crc     = crc7_word(tx_content);
    assign oIdle      = (state == ST_IDLE);

    // The shift register is reused: rotated out during SEND, refilled during RECV.
    always_ff @(posedge iClock_host) begin
        if (iReset) begin
            state       <= ST_RESET;
            shift       <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            rx_crc      <= '0;
            oCmd_line   <= 1'b1;
            oCmd_oe     <= 1'b0;
            oAck_out    <= 1'b0;
            oStrobe_out <= 1'b0;
            oCmd_out    <= '0;
            oCrc_error  <= 1'b0;
            oTimeout    <= 1'b0;
        end else begin
            oAck_out <= 1'b0;
            case (state)
                ST_RESET: state <= ST_IDLE;

                ST_IDLE: begin
                    if (iStrobe_in) begin
                        shift      <= {tx_content, tx_crc, 1'b1};
                        oCmd_line  <= tx_content[39];
                        oCmd_oe    <= 1'b1;
                        oAck_out   <= 1'b1;
                        oCrc_error <= 1'b0;
                        oTimeout   <= 1'b0;
                        bit_cnt    <= '0;
                        state      <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (iBit_tick) begin
                        if (bit_cnt == 6'd47) begin
                            oCmd_oe   <= 1'b0;
                            oCmd_line <= 1'b1;
                            bit_cnt   <= '0;
                            wait_cnt  <= '0;
                            state     <= ST_WAIT;
                        end else begin
                            shift     <= {shift[46:0], shift[47]};
                            oCmd_line <= shift[46];
                            bit_cnt   <= bit_cnt + 6'd1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (iBit_tick) begin
                        if (!iCmd_line) begin
                            shift   <= {shift[46:0], iCmd_line};
                            rx_crc  <= crc7_step(7'h00, iCmd_line);
                            bit_cnt <= 6'd1;
                            state   <= ST_RECV;
                        end else if (wait_cnt == WAIT_W'(RESP_TIMEOUT - 1)) begin
                            oTimeout    <= 1'b1;
                            oCmd_out    <= '0;
                            oStrobe_out <= 1'b1;
                            state       <= ST_DELIVER;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end

                // shift holds frame bits 47..1 when the end bit arrives on iCmd_line.
                ST_RECV: begin
                    if (iBit_tick) begin
                        shift <= {shift[46:0], iCmd_line};
                        if (bit_cnt < 6'd40) begin
                            rx_crc <= crc7_step(rx_crc, iCmd_line);
                        end
                        if (bit_cnt == 6'd47) begin
                            oCmd_out    <= shift[44:7];
                            oCrc_error  <= (shift[6:0] != rx_crc) || !iCmd_line;
                            oStrobe_out <= 1'b1;
                            state       <= ST_DELIVER;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end

                ST_DELIVER: begin
                    if (iAck_in) begin
                        oStrobe_out <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: state <= ST_RESET;
            endcase
        end
    end

endmodule
